// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the burst reader.
// Holds the memory block select codes, the reader FSM state enum and the
// default widths used as parameter defaults by mem_burst_reader.
package mem_pkg;

    localparam logic [1:0] MEM_SEL_WEIGHTS = 2'b00;
    localparam logic [1:0] MEM_SEL_INTER   = 2'b01;
    localparam logic [1:0] MEM_SEL_IO      = 2'b10;
    localparam logic [1:0] MEM_SEL_ILLEGAL = 2'b11;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/mem_rd_fifo.sv
// mem_rd_fifo: synchronous FIFO buffering read words ({last, data}) between
// the memory port and the output stream.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (flushes pointers/count)
//   push, wdata   write strobe and word; ignored when full unless popping
//   pop           read strobe; ignored when empty
//   rdata         head word, valid whenever count != 0 (zero latency)
//   count         number of stored words (0..DEPTH)
// DEPTH must be a power of two, at least 2.
module mem_rd_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: reads a burst of words from the memory manager port and
// streams them out through a valid/ready interface with a last marker.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_mem_select/base/len        target block, first address, word count
//   cmd_stride                     per-word address step (only with
//                                  MEM_BURST_READER_STRIDE_EN; else fixed 1)
//   mem_address/select/write_enable/data_out   memory manager port; read data
//                                  arrives the cycle after the address
//   out_valid/out_ready/out_data/out_last      output stream
//   busy, done, err                status; done/err are one-cycle pulses
// Build option: define MEM_BURST_READER_STRIDE_EN to add cmd_stride.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// ISSUE | presenting one read per cycle while the buffer has room
// DRAIN | all reads issued; waiting for the last word to leave
module mem_burst_reader
    import mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mem_select,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len,
`ifdef MEM_BURST_READER_STRIDE_EN
    input  logic [ADDR_W-1:0] cmd_stride,
`endif
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_select,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] remain_q;
    logic [ADDR_W-1:0] stride_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_d, err_d;
    logic              accept, issue;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;
    logic [DATA_W:0]   fifo_rdata;
    logic              fifo_empty;
    logic              pop;
    logic              head_last;

    assign fifo_empty       = (fifo_count == '0);
    assign out_valid        = !fifo_empty;
    // Gate the head so the stream outputs read zero while empty and in reset.
    assign out_data         = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
    assign head_last        = fifo_rdata[DATA_W];
    assign out_last         = !fifo_empty && head_last;
    assign pop              = out_valid && out_ready;
    // The read in flight already owns a buffer slot.
    assign occupancy        = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign cmd_ready        = (state_q == ST_IDLE) && !rst;
    assign busy             = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign mem_write_enable = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_mem_select == MEM_SEL_ILLEGAL) begin
                        err_d = 1'b1;
                    end else if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (occupancy < DEPTH_L) begin
                    issue = 1'b1;
                    if (remain_q == ADDR_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MEM_BURST_READER_STRIDE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q <= '0;
        end else if (accept) begin
            stride_q <= cmd_stride;
        end
    end
`else
    assign stride_q = ADDR_W'(1);
`endif

    // mem_address holds the address of the next read; it is loaded with the
    // base on acceptance so the first read goes out in the first ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_address     <= '0;
            mem_select      <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            done            <= done_d;
            err             <= err_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (remain_q == ADDR_W'(1));
            if (accept) begin
                mem_address <= cmd_base;
                mem_select  <= cmd_mem_select;
                remain_q    <= cmd_len;
            end else if (issue) begin
                remain_q <= remain_q - ADDR_W'(1);
                if (remain_q != ADDR_W'(1)) begin
                    mem_address <= mem_address + stride_q;
                end
            end
        end
    end

    mem_rd_fifo #(
        .WIDTH(DATA_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .wdata({inflight_last_q, mem_data_out}),
        .pop  (pop),
        .rdata(fifo_rdata),
        .count(fifo_count)
    );

endmodule

// File: tb/tb_mem_burst_reader.sv
module tb_mem_burst_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mem_select = 2'b00;
    logic [15:0] cmd_base = '0;
    logic [15:0] cmd_len = '0;
    logic [15:0] cmd_stride = 16'd1;
    logic [15:0] mem_address;
    logic [1:0]  mem_select;
    logic        mem_write_enable;
    logic [15:0] mem_data_out = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy, done, err;

    logic [15:0] mem [0:65535];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_data_out <= mem[mem_address];

    mem_burst_reader dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_mem_select  (cmd_mem_select),
        .cmd_base        (cmd_base),
        .cmd_len         (cmd_len),
`ifdef MEM_BURST_READER_STRIDE_EN
        .cmd_stride      (cmd_stride),
`endif
        .mem_address     (mem_address),
        .mem_select      (mem_select),
        .mem_write_enable(mem_write_enable),
        .mem_data_out    (mem_data_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " out_data"}, 32'(out_data), 0);
        chk({tag, " out_last"}, 32'(out_last), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " mem_address"}, 32'(mem_address), 0);
        chk({tag, " mem_select"}, 32'(mem_select), 0);
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 0);
        chk({tag, " mem_we"}, 32'(mem_write_enable), 0);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic send_cmd(input logic [1:0] sel, input logic [15:0] base,
                            input logic [15:0] len, input logic [15:0] stride);
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid      = 1'b1;
        cmd_mem_select = sel;
        cmd_base       = base;
        cmd_len        = len;
        cmd_stride     = stride;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Samples from the current negedge; expected word idx is first + idx*step.
    task automatic collect(input string tag, input logic [15:0] first, input logic [15:0] step,
                           input int total, input int n_take, input int stall,
                           input bit check_timing);
        int idx = 0;
        int cyc = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        logic [15:0] e;
        while (idx < n_take && cyc < stall + 4 * total + 20) begin
            out_ready = (cyc >= stall);
            if (stall > 0 && cyc == stall - 1)
                chk({tag, " buffered"}, 32'(dut.fifo_count), 4);
            if (out_valid && out_ready) begin
                e = first + 16'(idx) * step;
                chk({tag, " data"}, 32'(out_data), 32'(e));
                chk({tag, " last"}, 32'(out_last), 32'(idx == total - 1));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        chk({tag, " word_count"}, 32'(idx), 32'(n_take));
        if (check_timing) begin
            chk({tag, " first_latency"}, 32'(first_cyc), 2);
            chk({tag, " throughput"}, 32'(last_cyc - first_cyc), 32'(n_take - 1));
        end
        if (n_take == total) begin
            chk({tag, " done"}, 32'(done), 1);
            chk({tag, " busy_after"}, 32'(busy), 0);
            chk({tag, " ready_after"}, 32'(cmd_ready), 1);
            @(negedge clk);
            chk({tag, " done_pulse"}, 32'(done), 0);
            chk({tag, " drained"}, 32'(out_valid), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] addr_before;
        int residual;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i);

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle ready", 32'(cmd_ready), 1);
        chk("idle busy", 32'(busy), 0);

        // I/O buffer burst, timing and done pulse
        send_cmd(2'b10, 16'h0010, 16'd4, 16'd1);
        chk("io mem_select", 32'(mem_select), 2);
        chk("io busy", 32'(busy), 1);
        chk("io cmd_ready", 32'(cmd_ready), 0);
        collect("io", 16'h0010, 16'd1, 4, 4, 0, 1'b1);

        // address wrap
        send_cmd(2'b01, 16'hFFFE, 16'd3, 16'd1);
        collect("wrap", 16'hFFFE, 16'd1, 3, 3, 0, 1'b1);

        // long burst with stalled consumer
        send_cmd(2'b00, 16'h0200, 16'd20, 16'd1);
        collect("stall", 16'h0200, 16'd1, 20, 20, 10, 1'b0);

        // illegal select
        addr_before = mem_address;
        send_cmd(2'b11, 16'h0500, 16'd4, 16'd1);
        chk("illegal err", 32'(err), 1);
        chk("illegal ready", 32'(cmd_ready), 1);
        chk("illegal busy", 32'(busy), 0);
        chk("illegal addr", 32'(mem_address), 32'(addr_before));
        chk("illegal sel", 32'(mem_select), 0);
        @(negedge clk);
        chk("illegal err_pulse", 32'(err), 0);
        chk("illegal no_data", 32'(out_valid), 0);

        // zero length
        send_cmd(2'b10, 16'h0600, 16'd0, 16'd1);
        chk("zero done", 32'(done), 1);
        chk("zero err", 32'(err), 0);
        chk("zero busy", 32'(busy), 0);
        @(negedge clk);
        chk("zero done_pulse", 32'(done), 0);
        chk("zero no_data", 32'(out_valid), 0);

        // reset mid-burst
        send_cmd(2'b10, 16'h0300, 16'd8, 16'd1);
        collect("abort", 16'h0300, 16'd1, 8, 3, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        residual = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || done || busy) residual++;
        end
        chk("midrst residual", 32'(residual), 0);
        send_cmd(2'b01, 16'h0400, 16'd3, 16'd1);
        collect("after_rst", 16'h0400, 16'd1, 3, 3, 0, 1'b1);

`ifdef MEM_BURST_READER_STRIDE_EN
        send_cmd(2'b00, 16'h0100, 16'd3, 16'h0004);
        collect("stride", 16'h0100, 16'h0004, 3, 3, 0, 1'b1);
        send_cmd(2'b00, 16'h0120, 16'd3, 16'h0000);
        collect("stride0", 16'h0120, 16'h0000, 3, 3, 0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
